usb_tx_packet_framer: RTL and testbench
=======================================

Name: usb_tx_packet_framer

Overview:
Downstream consumer of the USB data buffer on the transmit path. On a start request it frames one USB packet at byte level: SYNC, PID, the payload drained from the buffer, then CRC16. Bytes go out over a valid/ready handshake to the bit-level serializer/NRZI encoder. The framer drives the buffer's Get_TX_Packet_Data strobe and consumes its registered TX_Packet_Data output.

Parameters:
SYNC_BYTE, 8'h80, SYNC byte value; the serializer sends LSB first, giving 0000_0001 on the wire.
MAX_PAYLOAD, 64, largest payload in bytes; must equal the buffer depth.

Ports:
clk  input  1  system clock
n_rst  input  1  reset, asynchronous, active-low
tx_start  input  1  one-cycle request to send a packet; sampled only in IDLE
tx_pid  input  4  PID[3:0] for the packet; sampled with tx_start
tx_abort  input  1  abandon the current packet
buffer_occupancy  input  7  buffer byte count (Buffer_Occupancy)
tx_packet_data  input  8  buffer output byte, valid the cycle after a get
get_tx_packet_data  output  1  one-cycle pop strobe to the buffer
tx_byte  output  8  byte to serializer
tx_byte_valid  output  1  tx_byte valid
tx_byte_ready  input  1  serializer accepts tx_byte this cycle
tx_last  output  1  qualifies the final byte of the packet; serializer appends EOP
tx_busy  output  1  high in any state other than IDLE
tx_done  output  1  one-cycle pulse after the last byte is accepted
tx_error  output  1  one-cycle pulse on illegal PID or payload overflow

Behaviour:
- Reset values: every output is 0, state is IDLE, the CRC register is 16'hFFFF and the counters are 0.
- PID classes:
  - Data: DATA0 4'b0011, DATA1 4'b1011.
  - Handshake: ACK 4'b0010, NAK 4'b1010, STALL 4'b1110.
  - Any other PID, or a data PID when buffer_occupancy > MAX_PAYLOAD: pulse tx_error the next cycle and stay in IDLE.
- Transfer rule: a byte transfers on a rising edge where tx_byte_valid && tx_byte_ready.
  - While valid is high and ready is low, tx_byte and tx_last hold stable.
  - Valid never drops without a transfer, except on abort.
- States and transitions:
  - IDLE: on tx_start with a legal PID, latch the PID and latch len = buffer_occupancy (a data PID only). Reset CRC to FFFF. Go to SYNC.
  - SYNC: tx_byte = SYNC_BYTE, valid = 1. On transfer go to PID.
  - PID: tx_byte = {~pid, pid}. tx_last = 1 for a handshake PID. On transfer: handshake PID goes to DONE; data PID with len == 0 goes to CRC_LO; otherwise FETCH.
  - FETCH: assert get_tx_packet_data for exactly one cycle with valid = 0, then go to LOAD.
  - LOAD: capture tx_packet_data into tx_byte, fold it into the CRC, decrement len, go to DATA.
  - DATA: valid = 1. On transfer: len == 0 goes to CRC_LO; otherwise FETCH.
  - CRC_LO: tx_byte = ~crc[7:0]. On transfer go to CRC_HI.
  - CRC_HI: tx_byte = ~crc[15:8], tx_last = 1. On transfer go to DONE.
  - DONE: pulse tx_done, return to IDLE.
- Payload fetch: the buffer output is valid only in the cycle after get and reads 0 otherwise. Capture happens exactly in LOAD. Minimum payload cadence is 3 cycles per byte.
- CRC16 (CRC-16/USB):
  - Reflected polynomial 16'hA001, init 16'hFFFF, processed LSB first over payload bytes only.
  - Per bit: fb = crc[0] ^ d[i]; crc = (crc >> 1) ^ (fb ? 16'hA001 : 16'h0000).
  - A byte-wide combinational unroll is required: one byte folds in per cycle.
  - The transmitted CRC is ~crc, low byte first.
- Payload length is frozen at start. Bytes stored into the buffer mid-packet are not sent in this packet. A flush of the buffer mid-packet does not shorten the packet.
- tx_start while tx_busy is ignored; tx_pid is not re-sampled.
- tx_abort, any non-IDLE state: next cycle state is IDLE and valid, last and get are 0. No tx_done, no tx_error. Popped bytes are not restored.
- tx_abort in IDLE has no effect. tx_abort and tx_start together in IDLE: abort wins, no packet.
- Asynchronous reset mid-packet: immediate return to the reset values. The next packet starts cleanly.
- len counter: 7 bits, covering 0..64 inclusive with no wrap.

Decomposition:
- Package usb_pkg holds:
  - the PID constants (DATA0, DATA1, ACK, NAK, STALL);
  - the state enum (IDLE, SYNC, PID, FETCH, LOAD, DATA, CRC_LO, CRC_HI, DONE);
  - CRC16_INIT 16'hFFFF and CRC16_POLY_REF 16'hA001.
- One sub-module, usb_crc16: clear, enable, 8-bit data in, 16-bit crc out, single-cycle byte update. It is reused later by the RX path for checking.

Test Plan:
- ACK with ready held high: tx_start with pid 4'b0010 → bytes 80, D2. tx_last is high on D2; tx_done pulses 1 cycle later. No get strobes.
- DATA0 with empty buffer: occupancy 0 → bytes 80, C3, 00, 00 (CRC of the empty payload). tx_last is high on the last 00.
- DATA1 with payload "123456789" (31..39, occupancy 9): exactly 9 get pulses → bytes 80, 4B, 31..39, C8, B4. This is the CRC-16/USB check value 0xB4C8.
- Backpressure: random tx_byte_ready with 64-byte payload 00..3F → tx_byte stable while stalled. Exactly 64 gets and 68 transfers in order, correct CRC, occupancy ends at 0.
- Illegal PID 4'b0001 → tx_error pulse, tx_busy stays 0, no gets. Also tx_start during busy → ignored; the packet completes unchanged.
- Abort after the 3rd payload byte → IDLE next cycle with valid 0. Occupancy drops by 3 only, no tx_done. The following ACK request frames correctly. Repeat with n_rst asserted mid-DATA.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, the transmit framer state set and CRC-16/USB constants.
package usb_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REF = 16'hA001;

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        PID,
        FETCH,
        LOAD,
        DATA,
        CRC_LO,
        CRC_HI,
        DONE
    } tx_state_t;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    function automatic logic is_handshake_pid(input logic [3:0] pid);
        return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// CRC-16/USB accumulator: reflected polynomial, one whole byte folded in per enabled cycle.
// Shared by the transmit framer and the receive-side checker.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_next;

    always_comb begin
        // NOTE: blocking assignments here chain the eight bit-steps within one evaluation.
        crc_next = crc_q;
        for (int i = 0; i < 8; i++) begin
            crc_next = {1'b0, crc_next[15:1]}
                     ^ ((crc_next[0] ^ data[i]) ? CRC16_POLY_REF : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: non-blocking assignments for every registered value, so all flops update together.
        if (!n_rst) begin
            crc_q <= CRC16_INIT;
        end else if (clear) begin
            crc_q <= CRC16_INIT;
        end else if (enable) begin
            crc_q <= crc_next;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_tx_packet_framer.sv
// Byte-level USB transmit framer: SYNC, PID, buffered payload and CRC16 out to the serializer
// over a valid/ready handshake.
module usb_tx_packet_framer
    import usb_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = 8'h80,
    parameter int         MAX_PAYLOAD = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_abort,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    input  logic       tx_byte_ready,
    output logic       tx_last,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam logic [6:0] MAX_LEN = 7'(MAX_PAYLOAD);

    tx_state_t   state_q, state_d;
    logic [3:0]  pid_q;
    logic [6:0]  len_q;
    logic [7:0]  data_q;
    logic        tx_error_q;
    logic [15:0] crc;
    logic        pid_legal;
    logic        start_ok;
    logic        xfer;

    assign pid_legal = is_handshake_pid(tx_pid)
                     || (is_data_pid(tx_pid) && (buffer_occupancy <= MAX_LEN));
    // Abort outranks a simultaneous start, so no packet is ever begun under abort.
    assign start_ok  = tx_start && !tx_abort && pid_legal;

    assign tx_byte_valid      = state_q inside {SYNC, PID, DATA, CRC_LO, CRC_HI};
    assign xfer               = tx_byte_valid && tx_byte_ready;
    assign get_tx_packet_data = (state_q == FETCH);
    assign tx_busy            = (state_q != IDLE);
    assign tx_done            = (state_q == DONE);
    assign tx_error           = tx_error_q;

    usb_crc16 u_crc (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  ((state_q == IDLE) && start_ok),
        .enable (state_q == LOAD),
        .data   (tx_packet_data),
        .crc    (crc)
    );

    always_comb begin
        // NOTE: defaults first for everything assigned below, so no path can infer a latch.
        state_d = state_q;
        tx_byte = 8'h00;
        tx_last = 1'b0;
        case (state_q)
            IDLE: if (start_ok) state_d = SYNC;
            SYNC: begin
                tx_byte = SYNC_BYTE;
                if (xfer) state_d = PID;
            end
            PID: begin
                tx_byte = {~pid_q, pid_q};
                tx_last = is_handshake_pid(pid_q);
                if (xfer) begin
                    if (is_handshake_pid(pid_q)) state_d = DONE;
                    else if (len_q == 7'd0)      state_d = CRC_LO;
                    else                         state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD:  state_d = DATA;
            DATA: begin
                tx_byte = data_q;
                if (xfer) state_d = (len_q == 7'd0) ? CRC_LO : FETCH;
            end
            CRC_LO: begin
                tx_byte = ~crc[7:0];
                if (xfer) state_d = CRC_HI;
            end
            CRC_HI: begin
                tx_byte = ~crc[15:8];
                tx_last = 1'b1;
                if (xfer) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tx_abort && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            pid_q      <= 4'h0;
            len_q      <= 7'd0;
            data_q     <= 8'h00;
            tx_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_error_q <= (state_q == IDLE) && tx_start && !tx_abort && !pid_legal;
            // Length is frozen here; later buffer writes or flushes do not alter this packet.
            if ((state_q == IDLE) && start_ok) begin
                pid_q <= tx_pid;
                len_q <= is_data_pid(tx_pid) ? buffer_occupancy : 7'd0;
            end
            if (state_q == LOAD) begin
                data_q <= tx_packet_data;
                len_q  <= len_q - 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_packet_framer.sv
// Directed bench for usb_tx_packet_framer with a behavioural data buffer and serializer.
module tb_usb_tx_packet_framer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [3:0] tx_pid = 4'h0;
    logic       tx_abort = 1'b0;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data = 8'h00;
    logic       get_tx_packet_data;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_ready = 1'b1;
    logic       tx_last;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    usb_tx_packet_framer dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_start           (tx_start),
        .tx_pid             (tx_pid),
        .tx_abort           (tx_abort),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_byte            (tx_byte),
        .tx_byte_valid      (tx_byte_valid),
        .tx_byte_ready      (tx_byte_ready),
        .tx_last            (tx_last),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done),
        .tx_error           (tx_error)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [256];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic       get_seen = 1'b0;
    int         rdy_mode = 1;      // 0: ready low, 1: ready high, 2: random
    int         n_get = 0;
    int         n_done = 0;
    int         n_err = 0;
    int         stall_err = 0;
    logic [7:0] got_b [$];
    logic       got_l [$];
    logic [7:0] exp_q [$];
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0] prev_b = 8'h00;
    logic       prev_l = 1'b0;

    assign buffer_occupancy = 7'(wr_cnt - rd_cnt);

    // Buffer pop: the byte appears the cycle after a get, reads 0 otherwise; ready driven here too.
    initial forever begin
        @(posedge clk);
        #1;
        if (get_seen) begin
            tx_packet_data = mem[rd_cnt & 255];
            rd_cnt++;
        end else begin
            tx_packet_data = 8'h00;
        end
        case (rdy_mode)
            0:       tx_byte_ready = 1'b0;
            1:       tx_byte_ready = 1'b1;
            default: tx_byte_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Serializer-side monitor, sampling mid-cycle.
    initial forever begin
        @(negedge clk);
        get_seen = get_tx_packet_data;
        if (n_rst) begin
            if (get_tx_packet_data) n_get++;
            if (tx_done) n_done++;
            if (tx_error) n_err++;
            if (prev_v && !prev_r) begin
                if (tx_byte_valid && (tx_byte !== prev_b || tx_last !== prev_l)) stall_err++;
                if (!tx_byte_valid) stall_err++;
            end
            if (tx_byte_valid && tx_byte_ready) begin
                got_b.push_back(tx_byte);
                got_l.push_back(tx_last);
            end
            prev_v = tx_byte_valid;
            prev_r = tx_byte_ready;
            prev_b = tx_byte;
            prev_l = tx_last;
        end else begin
            prev_v = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] crc_seq(input logic [7:0] base, input int n);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            b = base + 8'(k);
            for (int i = 0; i < 8; i++) begin
                if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
                else             c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic load_seq(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) mem[(wr_cnt + i) & 255] = base + 8'(i);
        wr_cnt += n;
    endtask

    task automatic flush_buf();
        wr_cnt = rd_cnt;
    endtask

    task automatic send_start(input logic [3:0] p);
        @(posedge clk);
        #2;
        tx_pid   = p;
        tx_start = 1'b1;
        @(posedge clk);
        #2;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (n_done > d0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        tx_start = 1'b0;
        tx_abort = 1'b0;
        rdy_mode = 1;
        n_rst    = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({tx_byte_valid, tx_last, tx_busy, tx_done, tx_error, get_tx_packet_data, tx_byte} !== 14'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {tx_byte_valid, tx_last, tx_busy, tx_done, tx_error, get_tx_packet_data, tx_byte});
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (tx_busy !== 1'b0 || tx_byte_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy %b valid %b expected 0 0", tx_busy, tx_byte_valid);
        end
    endtask

    task automatic test_ack();
        int q0, g0, d0;
        bit ok;
        flush_buf();
        q0 = got_b.size(); g0 = n_get; d0 = n_done;
        exp_q.delete();
        exp_q.push_back(8'h80); exp_q.push_back(8'hD2);
        send_start(4'b0010);
        wait_done(d0, 50, ok);
        tests++;
        if (ok !== 1'b1) begin fails++; $display("FAIL ack_done: got no tx_done expected one"); end
        tests++;
        if (got_b.size() - q0 != exp_q.size()) begin
            fails++;
            $display("FAIL ack_count: got %0d bytes expected %0d", got_b.size() - q0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (got_b[q0+i] !== exp_q[i] || got_l[q0+i] !== (i == exp_q.size() - 1)) begin
                    fails++;
                    $display("FAIL ack_byte%0d: got %h last %b expected %h last %b",
                             i, got_b[q0+i], got_l[q0+i], exp_q[i], (i == exp_q.size() - 1));
                end
            end
        end
        tests++;
        if (n_get - g0 != 0) begin fails++; $display("FAIL ack_gets: got %0d expected 0", n_get - g0); end
        @(negedge clk);
        #1;
        tests++;
        if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
            fails++;
            $display("FAIL ack_pulse: done %b busy %b expected 0 0", tx_done, tx_busy);
        end
    endtask

    task automatic test_data0_empty();
        int q0, d0;
        bit ok;
        flush_buf();
        q0 = got_b.size(); d0 = n_done;
        exp_q.delete();
        exp_q.push_back(8'h80); exp_q.push_back(8'hC3);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_start(4'b0011);
        wait_done(d0, 50, ok);
        tests++;
        if (ok !== 1'b1) begin fails++; $display("FAIL empty_done: got no tx_done expected one"); end
        tests++;
        if (got_b.size() - q0 != exp_q.size()) begin
            fails++;
            $display("FAIL empty_count: got %0d bytes expected %0d", got_b.size() - q0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (got_b[q0+i] !== exp_q[i] || got_l[q0+i] !== (i == exp_q.size() - 1)) begin
                    fails++;
                    $display("FAIL empty_byte%0d: got %h last %b expected %h last %b",
                             i, got_b[q0+i], got_l[q0+i], exp_q[i], (i == exp_q.size() - 1));
                end
            end
        end
    endtask

    task automatic test_data1_check_string();
        int q0, g0, d0;
        bit ok;
        flush_buf();
        load_seq(9, 8'h31);
        q0 = got_b.size(); g0 = n_get; d0 = n_done;
        exp_q.delete();
        exp_q.push_back(8'h80); exp_q.push_back(8'h4B);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
        exp_q.push_back(8'hC8); exp_q.push_back(8'hB4);
        send_start(4'b1011);
        load_seq(3, 8'hAA);   // written after start: must not join this packet
        wait_done(d0, 200, ok);
        tests++;
        if (ok !== 1'b1) begin fails++; $display("FAIL data1_done: got no tx_done expected one"); end
        tests++;
        if (got_b.size() - q0 != exp_q.size()) begin
            fails++;
            $display("FAIL data1_count: got %0d bytes expected %0d", got_b.size() - q0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (got_b[q0+i] !== exp_q[i] || got_l[q0+i] !== (i == exp_q.size() - 1)) begin
                    fails++;
                    $display("FAIL data1_byte%0d: got %h last %b expected %h last %b",
                             i, got_b[q0+i], got_l[q0+i], exp_q[i], (i == exp_q.size() - 1));
                end
            end
        end
        tests++;
        if (n_get - g0 != 9) begin fails++; $display("FAIL data1_gets: got %0d expected 9", n_get - g0); end
        tests++;
        if (buffer_occupancy !== 7'd3) begin
            fails++;
            $display("FAIL data1_occupancy: got %0d expected 3", buffer_occupancy);
        end
        flush_buf();
    endtask

    task automatic test_backpressure();
        int q0, g0, d0, s0;
        bit ok;
        logic [15:0] c;
        flush_buf();
        load_seq(64, 8'h00);
        c = crc_seq(8'h00, 64);
        q0 = got_b.size(); g0 = n_get; d0 = n_done; s0 = stall_err;
        exp_q.delete();
        exp_q.push_back(8'h80); exp_q.push_back(8'hC3);
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
        exp_q.push_back(~c[7:0]); exp_q.push_back(~c[15:8]);
        rdy_mode = 2;
        send_start(4'b0011);
        wait_done(d0, 3000, ok);
        rdy_mode = 1;
        tests++;
        if (ok !== 1'b1) begin fails++; $display("FAIL bp_done: got no tx_done expected one"); end
        tests++;
        if (got_b.size() - q0 != 68) begin
            fails++;
            $display("FAIL bp_count: got %0d bytes expected 68", got_b.size() - q0);
        end else begin
            for (int i = 0; i < 68; i++) begin
                tests++;
                if (got_b[q0+i] !== exp_q[i] || got_l[q0+i] !== (i == 67)) begin
                    fails++;
                    $display("FAIL bp_byte%0d: got %h last %b expected %h last %b",
                             i, got_b[q0+i], got_l[q0+i], exp_q[i], (i == 67));
                end
            end
        end
        tests++;
        if (n_get - g0 != 64) begin fails++; $display("FAIL bp_gets: got %0d expected 64", n_get - g0); end
        tests++;
        if (buffer_occupancy !== 7'd0) begin
            fails++;
            $display("FAIL bp_occupancy: got %0d expected 0", buffer_occupancy);
        end
        tests++;
        if (stall_err - s0 != 0) begin
            fails++;
            $display("FAIL bp_hold: got %0d unstable stalled cycles expected 0", stall_err - s0);
        end
    endtask

    task automatic test_illegal_and_busy_start();
        int q0, g0, d0, e0;
        bit ok;
        flush_buf();
        g0 = n_get; e0 = n_err;
        send_start(4'b0001);
        @(negedge clk);
        #1;
        tests++;
        if (tx_error !== 1'b1 || tx_busy !== 1'b0) begin
            fails++;
            $display("FAIL bad_pid: error %b busy %b expected 1 0", tx_error, tx_busy);
        end
        @(negedge clk);
        #1;
        tests++;
        if (tx_error !== 1'b0) begin fails++; $display("FAIL bad_pid_pulse: got %b expected 0", tx_error); end
        load_seq(65, 8'h00);
        send_start(4'b0011);
        @(negedge clk);
        #1;
        tests++;
        if (tx_error !== 1'b1 || tx_busy !== 1'b0) begin
            fails++;
            $display("FAIL overflow: error %b busy %b expected 1 0", tx_error, tx_busy);
        end
        flush_buf();
        repeat (2) @(negedge clk);
        tests++;
        if (n_err - e0 != 2 || n_get - g0 != 0) begin
            fails++;
            $display("FAIL error_totals: errors %0d gets %0d expected 2 0", n_err - e0, n_get - g0);
        end
        q0 = got_b.size(); d0 = n_done;
        rdy_mode = 0;
        send_start(4'b0010);
        repeat (2) @(posedge clk);
        send_start(4'b1011);   // must be ignored while busy
        rdy_mode = 1;
        wait_done(d0, 50, ok);
        repeat (6) @(negedge clk);
        #1;
        tests++;
        if (ok !== 1'b1 || n_done - d0 != 1 || tx_busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_start_done: ok %b dones %0d busy %b expected 1 1 0", ok, n_done - d0, tx_busy);
        end
        tests++;
        if (got_b.size() - q0 != 2) begin
            fails++;
            $display("FAIL busy_start_count: got %0d bytes expected 2", got_b.size() - q0);
        end else begin
            tests++;
            if (got_b[q0] !== 8'h80 || got_b[q0+1] !== 8'hD2 || got_l[q0+1] !== 1'b1) begin
                fails++;
                $display("FAIL busy_start_bytes: got %h %h last %b expected 80 d2 last 1",
                         got_b[q0], got_b[q0+1], got_l[q0+1]);
            end
        end
    endtask

    task automatic test_abort();
        int q0, d0, e0;
        bit ok;
        flush_buf();
        load_seq(10, 8'hA0);
        rdy_mode = 1;
        q0 = got_b.size(); d0 = n_done; e0 = n_err;
        send_start(4'b0011);
        for (int i = 0; i < 100 && (got_b.size() - q0 < 5); i++) begin
            @(negedge clk);
            #1;
        end
        tx_abort = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if ({tx_byte_valid, tx_last, get_tx_packet_data, tx_busy} !== 4'b0000) begin
            fails++;
            $display("FAIL abort_idle: got valid/last/get/busy %b expected 0000",
                     {tx_byte_valid, tx_last, get_tx_packet_data, tx_busy});
        end
        tx_abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (buffer_occupancy !== 7'd7) begin
            fails++;
            $display("FAIL abort_occupancy: got %0d expected 7", buffer_occupancy);
        end
        tests++;
        if (n_done - d0 != 0 || n_err - e0 != 0) begin
            fails++;
            $display("FAIL abort_pulses: dones %0d errors %0d expected 0 0", n_done - d0, n_err - e0);
        end
        tests++;
        if (got_b.size() - q0 != 5) begin
            fails++;
            $display("FAIL abort_count: got %0d bytes expected 5", got_b.size() - q0);
        end else begin
            tests++;
            if (got_b[q0+2] !== 8'hA0 || got_b[q0+3] !== 8'hA1 || got_b[q0+4] !== 8'hA2) begin
                fails++;
                $display("FAIL abort_bytes: got %h %h %h expected a0 a1 a2",
                         got_b[q0+2], got_b[q0+3], got_b[q0+4]);
            end
        end
        flush_buf();
        tx_abort = 1'b1;
        send_start(4'b0010);   // abort together with start: no packet
        tx_abort = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (tx_busy !== 1'b0) begin fails++; $display("FAIL abort_wins: busy %b expected 0", tx_busy); end
    endtask

    task automatic test_reset_mid_packet();
        int q0, d0;
        flush_buf();
        load_seq(10, 8'h50);
        q0 = got_b.size(); d0 = n_done;
        send_start(4'b0011);
        for (int i = 0; i < 100 && (got_b.size() - q0 < 4); i++) begin
            @(negedge clk);
            #1;
        end
        n_rst = 1'b0;
        #1;
        tests++;
        if ({tx_byte_valid, tx_busy, get_tx_packet_data, tx_byte} !== 11'h0) begin
            fails++;
            $display("FAIL rst_async: got valid/busy/get/byte %b expected zero",
                     {tx_byte_valid, tx_busy, get_tx_packet_data, tx_byte});
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        #1;
        tests++;
        if (buffer_occupancy !== 7'd8 || n_done - d0 != 0) begin
            fails++;
            $display("FAIL rst_occupancy: got %0d dones %0d expected 8 0", buffer_occupancy, n_done - d0);
        end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data0_empty();
        test_data1_check_string();
        test_backpressure();
        test_illegal_and_busy_start();
        test_abort();
        test_ack();
        test_reset_mid_packet();
        test_ack();
        test_data0_empty();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
